// File: rtl/idu.sv
// Instruction decode unit: decodes fetched RV32 words and buffers them in a two-entry
// output/skid pair. Optional feature macro: IDU_RV32E_EN (RV32E register-index check).
module idu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifu_valid,
  input  logic [31:0]      ifu_inst,
  input  logic [WIDTH-1:0] ifu_pc,
  output logic             ifu_ready,
  output logic             idu_valid,
  input  logic             idu_ready,
  output logic [WIDTH-1:0] idu_pc,
  output logic [6:0]       idu_opcode,
  output logic [2:0]       idu_funct3,
  output logic             idu_funct7b5,
  output logic [4:0]       idu_rs1,
  output logic [4:0]       idu_rs2,
  output logic [4:0]       idu_rd,
  output logic [31:0]      idu_imm,
  output logic [2:0]       idu_type,
  output logic             idu_wen,
  output logic             idu_illegal
);

  localparam logic [2:0] TypeR   = 3'd0;
  localparam logic [2:0] TypeI   = 3'd1;
  localparam logic [2:0] TypeS   = 3'd2;
  localparam logic [2:0] TypeB   = 3'd3;
  localparam logic [2:0] TypeU   = 3'd4;
  localparam logic [2:0] TypeJ   = 3'd5;
  localparam logic [2:0] TypeIll = 3'd7;

`ifdef IDU_RV32E_EN
  localparam bit RvE = 1'b1;
`else
  localparam bit RvE = 1'b0;
`endif

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [31:0]      imm;
    logic [2:0]       typ;
    logic             wen;
    logic             illegal;
  } dec_t;

  state_e state_q, state_d;
  dec_t   dec, out_q, skid_q;
  logic   push, pop;
  logic   load_out, load_skid, out_from_skid;
  logic   use_rs1, use_rs2, use_rd, wen_raw, ill_raw, rve_bad;

  // Combinational decode of the word currently offered by fetch.
  always_comb begin
    dec          = '0;
    dec.pc       = ifu_pc;
    dec.opcode   = ifu_inst[6:0];
    dec.funct3   = ifu_inst[14:12];
    dec.funct7b5 = ifu_inst[30];
    dec.rs1      = ifu_inst[19:15];
    dec.rs2      = ifu_inst[24:20];
    dec.rd       = ifu_inst[11:7];
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    use_rd       = 1'b0;
    wen_raw      = 1'b0;
    ill_raw      = 1'b0;
    unique case (ifu_inst[6:0])
      7'b0110111, 7'b0010111: begin
        dec.typ = TypeU;
        dec.imm = {ifu_inst[31:12], 12'b0};
        use_rd  = 1'b1;
        wen_raw = 1'b1;
      end
      7'b1101111: begin
        dec.typ = TypeJ;
        dec.imm = {{12{ifu_inst[31]}}, ifu_inst[19:12], ifu_inst[20], ifu_inst[30:21], 1'b0};
        use_rd  = 1'b1;
        wen_raw = 1'b1;
      end
      7'b1100111, 7'b0000011, 7'b0010011: begin
        dec.typ = TypeI;
        dec.imm = {{20{ifu_inst[31]}}, ifu_inst[31:20]};
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        wen_raw = 1'b1;
      end
      7'b1110011: begin
        dec.typ = TypeI;
        dec.imm = {{20{ifu_inst[31]}}, ifu_inst[31:20]};
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        wen_raw = (ifu_inst[14:12] != 3'b000);
      end
      7'b0100011: begin
        dec.typ = TypeS;
        dec.imm = {{20{ifu_inst[31]}}, ifu_inst[31:25], ifu_inst[11:7]};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b1100011: begin
        dec.typ = TypeB;
        dec.imm = {{19{ifu_inst[31]}}, ifu_inst[31], ifu_inst[7], ifu_inst[30:25],
                   ifu_inst[11:8], 1'b0};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0110011: begin
        dec.typ = TypeR;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        wen_raw = 1'b1;
      end
      default: ill_raw = 1'b1;
    endcase
    rve_bad = (use_rs1 & ifu_inst[19]) | (use_rs2 & ifu_inst[24]) | (use_rd & ifu_inst[11]);
    if (ill_raw || (RvE && rve_bad)) begin
      dec.illegal = 1'b1;
      dec.typ     = TypeIll;
      dec.imm     = '0;
      dec.wen     = 1'b0;
    end else begin
      dec.wen = wen_raw & (ifu_inst[11:7] != 5'd0);
    end
  end

  // Ready/valid depend on state_q only, keeping ifu_ready free of input paths.
  assign ifu_ready = (state_q != StTwo);
  assign idu_valid = (state_q != StEmpty);
  assign push      = ifu_valid & ifu_ready;
  assign pop       = idu_valid & idu_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StEmpty;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          state_d  = StOne;
          load_out = 1'b1;
        end
      end
      StOne: begin
        unique case ({push, pop})
          2'b11: load_out = 1'b1;
          2'b10: begin
            state_d   = StTwo;
            load_skid = 1'b1;
          end
          2'b01: state_d = StEmpty;
          default: ;
        endcase
      end
      StTwo: begin
        if (pop) begin
          state_d       = StOne;
          out_from_skid = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out)           out_q <= dec;
      else if (out_from_skid) out_q <= skid_q;
      if (load_skid)          skid_q <= dec;
    end
  end

  assign idu_pc       = out_q.pc;
  assign idu_opcode   = out_q.opcode;
  assign idu_funct3   = out_q.funct3;
  assign idu_funct7b5 = out_q.funct7b5;
  assign idu_rs1      = out_q.rs1;
  assign idu_rs2      = out_q.rs2;
  assign idu_rd       = out_q.rd;
  assign idu_imm      = out_q.imm;
  assign idu_type     = out_q.typ;
  assign idu_wen      = out_q.wen;
  assign idu_illegal  = out_q.illegal;

endmodule

// File: tb/tb_idu.sv
// Directed self-checking bench for idu; expected values hand-computed from RV32 encodings.
module tb_idu;
  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_valid;
  logic [31:0] ifu_inst;
  logic [31:0] ifu_pc;
  logic        ifu_ready;
  logic        idu_valid;
  logic        idu_ready;
  logic [31:0] idu_pc;
  logic [6:0]  idu_opcode;
  logic [2:0]  idu_funct3;
  logic        idu_funct7b5;
  logic [4:0]  idu_rs1, idu_rs2, idu_rd;
  logic [31:0] idu_imm;
  logic [2:0]  idu_type;
  logic        idu_wen;
  logic        idu_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  idu #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_valid    (ifu_valid),
    .ifu_inst     (ifu_inst),
    .ifu_pc       (ifu_pc),
    .ifu_ready    (ifu_ready),
    .idu_valid    (idu_valid),
    .idu_ready    (idu_ready),
    .idu_pc       (idu_pc),
    .idu_opcode   (idu_opcode),
    .idu_funct3   (idu_funct3),
    .idu_funct7b5 (idu_funct7b5),
    .idu_rs1      (idu_rs1),
    .idu_rs2      (idu_rs2),
    .idu_rd       (idu_rd),
    .idu_imm      (idu_imm),
    .idu_type     (idu_type),
    .idu_wen      (idu_wen),
    .idu_illegal  (idu_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
    ifu_valid = 1'b1;
    ifu_inst  = inst;
    ifu_pc    = pc;
  endtask

  initial begin
    rst       = 1'b1;
    ifu_valid = 1'b0;
    ifu_inst  = '0;
    ifu_pc    = '0;
    idu_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_ifu_ready", 32'(ifu_ready), 32'd1);
    chk("rst_idu_valid", 32'(idu_valid), 32'd0);
    chk("rst_pc", idu_pc, 32'd0);
    chk("rst_imm", idu_imm, 32'd0);
    chk("rst_fields", {idu_opcode, idu_funct3, idu_funct7b5, idu_rs1, idu_rs2, idu_rd,
                       idu_type, idu_wen, idu_illegal}, 32'd0);

    // addi x1,x0,5
    idu_ready = 1'b1;
    offer(32'h0050_0093, 32'h8000_0000);
    step();
    ifu_valid = 1'b0;
    chk("addi_valid", 32'(idu_valid), 32'd1);
    chk("addi_type", 32'(idu_type), 32'd1);
    chk("addi_rd", 32'(idu_rd), 32'd1);
    chk("addi_imm", idu_imm, 32'd5);
    chk("addi_wen", 32'(idu_wen), 32'd1);
    chk("addi_pc", idu_pc, 32'h8000_0000);
    step();
    chk("addi_popped", 32'(idu_valid), 32'd0);

    // beq then lui x0 back-to-back with execute stalled
    idu_ready = 1'b0;
    offer(32'hFE00_0EE3, 32'h8000_0004);
    step();
    chk("beq_type", 32'(idu_type), 32'd3);
    chk("beq_imm", idu_imm, 32'hFFFF_FFFC);
    chk("beq_ready_one", 32'(ifu_ready), 32'd1);
    offer(32'h1234_5037, 32'h8000_0008);
    step();
    ifu_valid = 1'b0;
    chk("two_ifu_ready", 32'(ifu_ready), 32'd0);
    chk("two_head_pc", idu_pc, 32'h8000_0004);
    step();
    chk("two_hold_imm", idu_imm, 32'hFFFF_FFFC);
    chk("two_hold_ready", 32'(ifu_ready), 32'd0);
    idu_ready = 1'b1;
    step();
    chk("lui_type", 32'(idu_type), 32'd4);
    chk("lui_imm", idu_imm, 32'h1234_5000);
    chk("lui_wen", 32'(idu_wen), 32'd0);
    chk("lui_pc", idu_pc, 32'h8000_0008);
    chk("lui_ifu_ready", 32'(ifu_ready), 32'd1);
    step();
    chk("lui_popped", 32'(idu_valid), 32'd0);

    // Stream of 8: addi x1,x0,i, one per cycle
    for (int i = 0; i < 8; i++) begin
      offer((32'(i) << 20) | 32'h93, 32'h100 + 32'(4 * i));
      step();
      chk("strm_valid", 32'(idu_valid), 32'd1);
      chk("strm_imm", idu_imm, 32'(i));
      chk("strm_pc", idu_pc, 32'h100 + 32'(4 * i));
      chk("strm_ready", 32'(ifu_ready), 32'd1);
    end
    ifu_valid = 1'b0;
    step();
    chk("strm_drained", 32'(idu_valid), 32'd0);

    // Other formats, streamed with idu_ready high
    offer(32'h0020_A423, 32'h200); // sw x2,8(x1)
    step();
    chk("sw_type", 32'(idu_type), 32'd2);
    chk("sw_imm", idu_imm, 32'd8);
    chk("sw_wen", 32'(idu_wen), 32'd0);
    chk("sw_regs", {22'd0, idu_rs1, idu_rs2}, {22'd0, 5'd1, 5'd2});
    chk("sw_f3", 32'(idu_funct3), 32'd2);
    offer(32'h0080_00EF, 32'h204); // jal x1,8
    step();
    chk("jal_type", 32'(idu_type), 32'd5);
    chk("jal_imm", idu_imm, 32'd8);
    chk("jal_wen", 32'(idu_wen), 32'd1);
    offer(32'h4020_81B3, 32'h208); // sub x3,x1,x2
    step();
    chk("sub_type", 32'(idu_type), 32'd0);
    chk("sub_imm", idu_imm, 32'd0);
    chk("sub_f7b5", 32'(idu_funct7b5), 32'd1);
    chk("sub_rd", 32'(idu_rd), 32'd3);
    chk("sub_wen", 32'(idu_wen), 32'd1);
    offer(32'h0000_0073, 32'h20C); // ecall
    step();
    chk("ecall_type", 32'(idu_type), 32'd1);
    chk("ecall_wen", 32'(idu_wen), 32'd0);
    offer(32'h0000_007F, 32'h210); // illegal opcode
    step();
    ifu_valid = 1'b0;
    chk("ill_flag", 32'(idu_illegal), 32'd1);
    chk("ill_type", 32'(idu_type), 32'd7);
    chk("ill_imm", idu_imm, 32'd0);
    chk("ill_wen", 32'(idu_wen), 32'd0);
    step();

    // Register-index range check
    offer(32'h0100_0093, 32'h300); // addi x1,x0,16
    step();
    chk("x1_legal", 32'(idu_illegal), 32'd0);
    chk("x1_imm", idu_imm, 32'd16);
    offer(32'h0008_0813, 32'h304); // addi x16,x16,0
    step();
    ifu_valid = 1'b0;
`ifdef IDU_RV32E_EN
    chk("x16_illegal", 32'(idu_illegal), 32'd1);
    chk("x16_type", 32'(idu_type), 32'd7);
    chk("x16_wen", 32'(idu_wen), 32'd0);
`else
    chk("x16_legal", 32'(idu_illegal), 32'd0);
    chk("x16_type", 32'(idu_type), 32'd1);
    chk("x16_wen", 32'(idu_wen), 32'd1);
`endif
    step();

    // Reset while TWO entries are buffered
    idu_ready = 1'b0;
    offer(32'h00A0_0093, 32'h400);
    step();
    offer(32'h00B0_0093, 32'h404);
    step();
    ifu_valid = 1'b0;
    chk("pre_rst_two", 32'(ifu_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(idu_valid), 32'd0);
    chk("mid_rst_ready", 32'(ifu_ready), 32'd1);
    chk("mid_rst_imm", idu_imm, 32'd0);
    chk("mid_rst_pc", idu_pc, 32'd0);
    step();
    rst = 1'b0;
    idu_ready = 1'b1;
    step();
    step();
    chk("post_rst_empty", 32'(idu_valid), 32'd0);
    offer(32'h00C0_0093, 32'h500);
    step();
    ifu_valid = 1'b0;
    chk("post_rst_imm", idu_imm, 32'd12);
    chk("post_rst_pc", idu_pc, 32'h500);
    step();
    chk("post_rst_drain", 32'(idu_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/idu.md
# idu

Instruction decode unit of the multi-cycle NPC core, directly downstream of the instruction fetch stage. Accepts fetched instructions over a valid/ready handshake, decodes each into register indices, sign-extended immediate, format class, write-enable and an illegal flag, then presents the result to the execute stage over a second valid/ready handshake. A two-entry output buffer (output register plus skid register) sustains one instruction per cycle while keeping `ifu_ready` a function of registered state only.

## Interface
- `WIDTH`, 32, PC width in bits.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ifu_valid`  in  1  fetch stage holds a valid instruction.
- `ifu_inst`  in  32  instruction word.
- `ifu_pc`  in  WIDTH  PC of `ifu_inst`.
- `ifu_ready`  out  1  IDU accepts this cycle; derived from state register only.
- `idu_valid`  out  1  decoded instruction present on `idu_*`.
- `idu_ready`  in  1  execute stage accepts.
- `idu_pc`  out  WIDTH  PC of the decoded instruction.
- `idu_opcode`  out  7  `inst[6:0]`.
- `idu_funct3`  out  3  `inst[14:12]`.
- `idu_funct7b5`  out  1  `inst[30]`.
- `idu_rs1`, `idu_rs2`, `idu_rd`  out  5 each  register indices.
- `idu_imm`  out  32  sign-extended immediate.
- `idu_type`  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- `idu_wen`  out  1  register write-back required.
- `idu_illegal`  out  1  undecodable instruction.

## Operation
- Push = `ifu_valid & ifu_ready`; pop = `idu_valid & idu_ready`.
- Decode is combinational on `ifu_inst`; the result is captured at push. Captured words are never re-decoded.
- Legal opcodes (`inst[1:0]` must be `11`): LUI 0110111, AUIPC 0010111 (U); JAL 1101111 (J); JALR 1100111, LOAD 0000011, OP-IMM 0010011, SYSTEM 1110011 (I); STORE 0100011 (S); BRANCH 1100011 (B); OP 0110011 (R). Anything else: `idu_illegal`=1, `idu_type`=7, `idu_imm`=0, `idu_wen`=0.
- Immediates per RV32 base encoding, sign bit `inst[31]`; U-type = `{inst[31:12],12'b0}`; R-type imm = 0.
- `idu_wen` = 1 for U, J, JALR, LOAD, OP-IMM, OP, and SYSTEM with funct3≠0; forced 0 when `rd`=0 or illegal.
- Field outputs (`rs1/rs2/rd/funct*`) are raw bit slices regardless of format.
- State machine (buffer occupancy):
  - EMPTY: `idu_valid`=0, `ifu_ready`=1. Push → ONE (output reg loads).
  - ONE: `idu_valid`=1, `ifu_ready`=1. Push&pop → ONE (output reg reloads); push only → TWO (skid loads); pop only → EMPTY.
  - TWO: `idu_valid`=1, `ifu_ready`=0. Pop → ONE (skid moves to output reg); else hold.
- Ordering strictly FIFO; output register always holds the oldest entry.
- `idu_*` data stable while `idu_valid & !idu_ready`.

## Timing
- Latency: push at edge N → `idu_valid`=1 from N (output visible in cycle after N), one cycle total.
- Throughput: one instruction per cycle when `idu_ready` stays high.
- `ifu_ready` deasserts only in TWO; reasserts the cycle after a pop from TWO.
- Reset (any time, including mid-transfer): state EMPTY, `idu_valid`=0, `ifu_ready`=1, all `idu_*` data outputs 0; buffered instructions discarded.
- No combinational path from `idu_ready` or `ifu_valid` to `ifu_ready`.

## Configuration
- `IDU_RV32E_EN` defined: RV32E register file; any used register index (`rs1`, `rs2`, `rd` as applicable to the format) with bit 4 set marks the instruction illegal (`idu_type`=7, `idu_wen`=0).
- Not defined: RV32I, all 32 register indices legal.

## Test plan
- Reset release, `ifu_valid`=0 → `ifu_ready`=1, `idu_valid`=0, all data 0.
- Push `0x00500093` (addi x1,x0,5), pc 0x80000000, `idu_ready`=1 → next cycle `idu_type`=1, `idu_rd`=1, `idu_imm`=5, `idu_wen`=1, `idu_pc`=0x80000000.
- Push `0xFE000EE3` (beq x0,x0,-4) then `0x12345037` (lui x0) back-to-back with `idu_ready`=0 → after two pushes `ifu_ready`=0; B output imm=0xFFFFFFFC; after one pop, LUI shown, imm=0x12345000, `idu_wen`=0 (rd=0), `ifu_ready`=1 next cycle.
- Continuous stream of 8 instructions with `idu_ready`=1 → 8 pops in 8 consecutive cycles, order preserved.
- Push `0x0000007F` → `idu_illegal`=1, `idu_type`=7, `idu_imm`=0; with `IDU_RV32E_EN`, `0x01000093` (addi x1,x0,16 — legal) vs `0x00080813` (addi x16,x16,0) → latter illegal.
- Assert `rst` while in TWO → immediately `idu_valid`=0, `ifu_ready`=1; previously buffered words never appear.
